// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and framing constants.
package loader_pkg;

    localparam int unsigned BYTE_WIDTH     = 8;
    localparam int unsigned BYTES_PER_WORD = 2;
    localparam int unsigned WORD_WIDTH     = BYTE_WIDTH * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction RAM write port of the program loader.
interface prog_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (output in_valid, output in_data, input in_ready,
                    input mem_we, input mem_addr, input mem_wdata);
    modport slave  (input in_valid, input in_data, output in_ready,
                    output mem_we, output mem_addr, output mem_wdata);
endinterface

// File: rtl/prog_loader_xor_accum.sv
// 8-bit running XOR of the frame bytes, with a compare against the checksum byte.
module xor_accum
    import loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  update,
    input  logic [BYTE_WIDTH-1:0] din,
    output logic [BYTE_WIDTH-1:0] acc,
    output logic                  match_c
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (init) begin
            acc <= din;
        end else if (update) begin
            acc <= acc ^ din;
        end
    end

    assign match_c = (acc == din);

endmodule

// File: rtl/prog_loader.sv
// Loads a framed byte stream into instruction RAM and holds the CPU in reset until
// the image checksum has been verified.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WORD_WIDTH,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic           clk,
    input  logic           pc_reset,
    input  logic           start,
    prog_loader_if.slave   bus,
    output logic           cpu_hold,
    output logic           done,
    output logic           error
);

    state_e                state_q, state_d;
    logic [7:0]            count_q, count_d;
    logic [7:0]            index_q, index_d;
    logic [7:0]            hi_q, hi_d;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  acc_init, acc_update;
    logic [7:0]            acc;
    logic                  match_c;
    logic                  xfer;

    xor_accum u_xor (
        .clk     (clk),
        .rst     (pc_reset),
        .init    (acc_init),
        .update  (acc_update),
        .din     (bus.in_data),
        .acc     (acc),
        .match_c (match_c)
    );

    // in_ready is a registered state decode, so xfer never loops back into in_ready.
    assign xfer = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        hi_d       = hi_q;
        we_d       = 1'b0;
        addr_d     = bus.mem_addr;
        wdata_d    = bus.mem_wdata;
        acc_init   = 1'b0;
        acc_update = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_d = S_COUNT;
            end
            S_COUNT: begin
                if (xfer) begin
                    count_d  = bus.in_data;
                    index_d  = 8'd0;
                    acc_init = 1'b1;
                    state_d  = (bus.in_data == 8'd0) ? S_CHECK : S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d       = bus.in_data;
                    acc_update = 1'b1;
                    state_d    = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    acc_update = 1'b1;
                    we_d       = 1'b1;
                    addr_d     = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(index_q);
                    wdata_d    = DATA_WIDTH'({hi_q, bus.in_data});
                    if ((9'(index_q) + 9'd1) == 9'(count_q)) begin
                        state_d = S_CHECK;
                    end else begin
                        index_d = 8'(index_q + 8'd1);
                        state_d = S_HI;
                    end
                end
            end
            S_CHECK: begin
                if (xfer) state_d = match_c ? S_DONE : S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered decodes of the next state, so they track state_q exactly.
    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            index_q       <= '0;
            hi_q          <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            index_q       <= index_d;
            hi_q          <= hi_d;
            bus.in_ready  <= (state_d == S_COUNT) || (state_d == S_HI) ||
                             (state_d == S_LO)    || (state_d == S_CHECK);
            bus.mem_we    <= we_d;
            bus.mem_addr  <= addr_d;
            bus.mem_wdata <= wdata_d;
            cpu_hold      <= (state_d != S_DONE);
            done          <= (state_d == S_DONE);
            error         <= (state_d == S_ERROR);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: frames are modelled as byte lists and expected RAM writes queued.
module tb_prog_loader;

    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 16;
    localparam int unsigned BASE = 8'hFE;

    logic clk = 1'b0;
    logic pc_reset;
    logic start;
    logic cpu_hold, done, error;

    int tests    = 0;
    int failures = 0;

    logic [23:0] wq[$];

    prog_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .pc_reset (pc_reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!pc_reset && bus.mem_we === 1'b1) begin
            if (wq.size() == 0) begin
                tests++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                logic [23:0] e;
                e = wq.pop_front();
                check("write_addr", 32'(bus.mem_addr), 32'(e[23:16]));
                check("write_data", 32'(bus.mem_wdata), 32'(e[15:0]));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stalls);
        int guard = 0;
        forever begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                check("send_timeout", 32'(bus.in_ready), 32'd1);
                bus.in_valid = 1'b0;
                break;
            end
            if (stalls && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                continue;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = b;
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_in_ready", 32'(bus.in_ready), 32'd1);
        check("start_done",     32'(done),         32'd0);
        check("start_error",    32'(error),        32'd0);
        check("start_cpu_hold", 32'(cpu_hold),     32'd1);
    endtask

    // Frame model: checksum is the XOR of every byte before CHK; word i lands at (BASE+i) mod 256.
    task automatic run_frame(input logic [15:0] words[$], input logic [7:0] chk,
                             input bit stalls, input bit inject_start);
        logic [7:0] x;
        bit         ok;
        int         n;
        n = words.size();
        x = 8'(n);
        for (int i = 0; i < n; i++) begin
            x = x ^ words[i][15:8] ^ words[i][7:0];
            wq.push_back({8'((BASE + i) % 256), words[i]});
        end
        ok = (chk == x);
        do_start();
        send_byte(8'(n), stalls);
        for (int i = 0; i < n; i++) begin
            if (inject_start && i == 0) begin
                @(negedge clk);
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            send_byte(words[i][15:8], stalls);
            send_byte(words[i][7:0], stalls);
        end
        send_byte(chk, stalls);
        check("frame_done",     32'(done),      32'(ok));
        check("frame_error",    32'(error),     32'(!ok));
        check("frame_cpu_hold", 32'(cpu_hold),  32'(!ok));
        check("frame_in_ready", 32'(bus.in_ready), 32'd0);
        check("writes_pending", 32'(wq.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready),  32'd0);
        check({tag, "_mem_we"},   32'(bus.mem_we),    32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr),  32'd0);
        check({tag, "_wdata"},    32'(bus.mem_wdata), 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold),      32'd1);
        check({tag, "_done"},     32'(done),          32'd0);
        check({tag, "_error"},    32'(error),         32'd0);
    endtask

    initial begin
        logic [15:0] w[$];
        logic [7:0]  x;
        int          n;

        pc_reset     = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        pc_reset = 1'b0;

        // Bytes offered in IDLE must be ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hAA;
            check("idle_not_ready", 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;

        // Nominal image, then the same with a bad checksum.
        w = '{16'h1234, 16'hABCD};
        run_frame(w, 8'h42, 1'b0, 1'b0);
        w = '{16'h1234, 16'hABCD};
        run_frame(w, 8'h43, 1'b0, 1'b0);

        // Empty image.
        w = {};
        run_frame(w, 8'h00, 1'b0, 1'b0);

        // Wrap past the top of RAM with random stalls and a start pulse mid-frame.
        w = '{16'h0102, 16'hF00D, 16'hBEEF};
        run_frame(w, 8'h03 ^ 8'h01 ^ 8'h02 ^ 8'hF0 ^ 8'h0D ^ 8'hBE ^ 8'hEF, 1'b1, 1'b1);

        // Reset after the high byte of the second word.
        do_start();
        send_byte(8'h02, 1'b0);
        wq.push_back({8'hFE, 16'h5566});
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        #2;
        pc_reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        check("midreset_writes", 32'(wq.size()), 32'd0);
        wq.delete();
        @(negedge clk);
        pc_reset = 1'b0;
        w = '{16'h1111, 16'h2222};
        run_frame(w, 8'h02, 1'b0, 1'b0);

        // Randomised frames against the model.
        for (int t = 0; t < 12; t++) begin
            w = {};
            n = $urandom_range(0, 6);
            x = 8'(n);
            for (int i = 0; i < n; i++) begin
                w.push_back(16'($urandom));
                x = x ^ w[i][15:8] ^ w[i][7:0];
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
            run_frame(w, x, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
